// File: rtl/slink_tx_framer_pkg.sv
// Shared line codes, CRC constants and FSM encoding for the slink transmit framer.
package slink_tx_framer_pkg;

    localparam logic [15:0] IDLE_WORD  = 16'hBC50;
    localparam logic [15:0] SYNC_WORD  = 16'hEB90;
    localparam logic [15:0] ABORT_WORD = 16'hFE00;
    localparam logic [15:0] CRC_POLY   = 16'h1021;
    localparam logic [15:0] CRC_INIT   = 16'hFFFF;

    localparam int unsigned SOP_BIT = 17;
    localparam int unsigned EOP_BIT = 16;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StBody,
        StCrc,
        StGap,
        StAbort
    } state_e;

    // CRC-16/CCITT over one word; high byte then low byte, MSB first == bits 15 down to 0.
    function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/slink_rxbuf.sv
// Synchronous show-ahead FIFO with occupancy output; the writer guarantees no overflow.
module slink_rxbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign empty   = (count == '0);

endmodule

// File: rtl/slink_tx_framer.sv
// Frames buffered upstream words into sync / payload / CRC / gap sequences on a 16-bit line.
module slink_tx_framer
    import slink_tx_framer_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned MAX_LEN   = 1024,
    parameter int unsigned GAP_WORDS = 2
) (
    input  logic        clk_12_5m,
    input  logic        rst_12_5m,
    input  logic        tx_en,
    input  logic        mmtx_slink_dval,
    input  logic [17:0] mmtx_slink_data,
    output logic        slink_mmtx_rdreq,
    output logic [15:0] tx_data,
    output logic        tx_kflag,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        err_underrun,
    output logic        err_sync,
    output logic        err_len,
    output logic [15:0] frm_cnt
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned GW = $clog2(GAP_WORDS + 1);

    logic [17:0]   head;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    logic          head_valid;
    logic          head_sop;
    logic          pop;
    logic          idle_decide;
    logic          len_full;
    logic          rdreq_d;
    logic [SW-1:0] occ_sum;

    state_e        state_q;
    logic [15:0]   crc_q;
    logic [LW-1:0] len_q;
    logic          last_q;
    logic          drop_q;
    logic [GW-1:0] gap_cnt_q;

    slink_rxbuf #(
        .DEPTH(BUF_DEPTH),
        .WIDTH(18)
    ) u_rxbuf (
        .clk    (clk_12_5m),
        .rst    (rst_12_5m),
        .wr_en  (mmtx_slink_dval),
        .wr_data(mmtx_slink_data),
        .rd_en  (pop),
        .rd_data(head),
        .empty  (buf_empty),
        .count  (buf_count)
    );

    assign head_valid = !buf_empty;
    assign head_sop   = head[SOP_BIT];

    always_comb begin
        // The last gap word doubles as an idle decision so a queued SOP follows without a bubble.
        idle_decide = (state_q == StIdle) || (state_q == StGap && gap_cnt_q == GW'(GAP_WORDS));
        len_full    = (len_q == LW'(MAX_LEN));
        pop         = 1'b0;
        if (idle_decide) begin
            pop = head_valid && !head_sop;
        end else if (state_q == StAbort || state_q == StGap) begin
            pop = drop_q && head_valid && !head_sop;
        end else if (state_q == StSync) begin
            pop = !len_full && head_valid;
        end else if (state_q == StBody) begin
            pop = !last_q && !len_full && head_valid && !head_sop;
        end
        // Count the word landing now and the one already requested so the buffer never overflows.
        occ_sum = SW'(buf_count) + SW'(mmtx_slink_dval) + SW'(slink_mmtx_rdreq) - SW'(pop);
        rdreq_d = tx_en && (occ_sum < SW'(BUF_DEPTH));
    end

    always_ff @(posedge clk_12_5m or posedge rst_12_5m) begin
        if (rst_12_5m) begin
            state_q          <= StIdle;
            crc_q            <= CRC_INIT;
            len_q            <= '0;
            last_q           <= 1'b0;
            drop_q           <= 1'b0;
            gap_cnt_q        <= '0;
            slink_mmtx_rdreq <= 1'b0;
            tx_data          <= IDLE_WORD;
            tx_kflag         <= 1'b1;
            tx_sof           <= 1'b0;
            tx_eof           <= 1'b0;
            err_underrun     <= 1'b0;
            err_sync         <= 1'b0;
            err_len          <= 1'b0;
            frm_cnt          <= '0;
        end else begin
            slink_mmtx_rdreq <= rdreq_d;
            tx_sof           <= 1'b0;
            tx_eof           <= 1'b0;
            err_underrun     <= 1'b0;
            err_sync         <= 1'b0;
            err_len          <= 1'b0;
            drop_q           <= drop_q && head_valid && !head_sop;

            if (idle_decide) begin
                state_q  <= StIdle;
                tx_data  <= IDLE_WORD;
                tx_kflag <= 1'b1;
                if (head_valid && head_sop) begin
                    state_q <= StSync;
                    tx_data <= SYNC_WORD;
                    tx_sof  <= 1'b1;
                    crc_q   <= CRC_INIT;
                    len_q   <= '0;
                    last_q  <= 1'b0;
                end else if (head_valid && !drop_q) begin
                    err_sync <= 1'b1;
                end
            end else begin
                case (state_q)
                    StCrc, StAbort: begin
                        state_q   <= StGap;
                        tx_data   <= IDLE_WORD;
                        tx_kflag  <= 1'b1;
                        gap_cnt_q <= GW'(1);
                    end
                    StGap: begin
                        tx_data   <= IDLE_WORD;
                        tx_kflag  <= 1'b1;
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                    default: begin
                        if (last_q) begin
                            state_q  <= StCrc;
                            tx_data  <= crc_q;
                            tx_kflag <= 1'b0;
                            tx_eof   <= 1'b1;
                            frm_cnt  <= frm_cnt + 16'd1;
                        end else if (len_full || !head_valid ||
                                     (state_q == StBody && head_sop)) begin
                            state_q      <= StAbort;
                            tx_data      <= ABORT_WORD;
                            tx_kflag     <= 1'b1;
                            tx_eof       <= 1'b1;
                            drop_q       <= 1'b1;
                            err_len      <= len_full;
                            err_underrun <= !len_full && !head_valid;
                            err_sync     <= !len_full && head_valid;
                        end else begin
                            state_q  <= StBody;
                            tx_data  <= head[15:0];
                            tx_kflag <= 1'b0;
                            crc_q    <= crc16_word(crc_q, head[15:0]);
                            len_q    <= len_q + LW'(1);
                            last_q   <= head[EOP_BIT];
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_slink_tx_framer.sv
// Directed self-checking bench for slink_tx_framer with a 1-cycle-latency upstream responder.
module tb_slink_tx_framer;

    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned MAX_LEN   = 1024;
    localparam int unsigned GAP_WORDS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b1;
    logic        dval = 1'b0;
    logic [17:0] data = '0;
    logic        rdreq;
    logic [15:0] tx_data;
    logic        tx_kflag, tx_sof, tx_eof;
    logic        err_underrun, err_sync, err_len;
    logic [15:0] frm_cnt;

    int checks = 0;
    int errors = 0;
    int exp_frm = 0;
    int occ_max = 0;
    logic        pend = 1'b0;
    logic [17:0] src[$];
    logic [15:0] payload[$];

    slink_tx_framer #(
        .BUF_DEPTH(BUF_DEPTH),
        .MAX_LEN  (MAX_LEN),
        .GAP_WORDS(GAP_WORDS)
    ) dut (
        .clk_12_5m       (clk),
        .rst_12_5m       (rst),
        .tx_en           (tx_en),
        .mmtx_slink_dval (dval),
        .mmtx_slink_data (data),
        .slink_mmtx_rdreq(rdreq),
        .tx_data         (tx_data),
        .tx_kflag        (tx_kflag),
        .tx_sof          (tx_sof),
        .tx_eof          (tx_eof),
        .err_underrun    (err_underrun),
        .err_sync        (err_sync),
        .err_len         (err_len),
        .frm_cnt         (frm_cnt)
    );

    always #40 clk = ~clk;

    // Upstream: a request seen in one cycle returns a word in the next, if one is queued.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            dval = 1'b0;
        end else begin
            if (pend && src.size() > 0) begin
                dval = 1'b1;
                data = src.pop_front();
            end else begin
                dval = 1'b0;
            end
            pend = rdreq;
        end
    end

    always @(negedge clk) begin
        if (int'(dut.buf_count) > occ_max) occ_max = int'(dut.buf_count);
    end

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] w);
        return crc_byte(crc_byte(c, w[15:8]), w[7:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] d, input logic k,
                            input logic s, input logic e);
        chk(tag, {13'b0, tx_kflag, tx_sof, tx_eof, tx_data}, {13'b0, k, s, e, d});
    endtask

    task automatic push_frame();
        for (int i = 0; i < payload.size(); i++)
            src.push_back({(i == 0), (i == payload.size() - 1), payload[i]});
    endtask

    task automatic wait_sof(input string tag);
        int n;
        n = 0;
        step();
        while (tx_sof !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_sync"}, {13'b0, tx_kflag, tx_sof, tx_eof, tx_data},
            {13'b0, 1'b1, 1'b1, 1'b0, 16'hEB90});
    endtask

    task automatic check_frame(input string tag, input bit immediate);
        logic [15:0] crc;
        if (immediate) begin
            step();
            chk_word({tag, "_sync_now"}, 16'hEB90, 1'b1, 1'b1, 1'b0);
        end else begin
            wait_sof(tag);
        end
        crc = 16'hFFFF;
        for (int i = 0; i < payload.size(); i++) begin
            step();
            chk_word({tag, "_data"}, payload[i], 1'b0, 1'b0, 1'b0);
            crc = crc_word(crc, payload[i]);
        end
        step();
        chk_word({tag, "_crc"}, crc, 1'b0, 1'b0, 1'b1);
        exp_frm++;
        chk({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_frm));
        for (int g = 0; g < GAP_WORDS; g++) begin
            step();
            chk_word({tag, "_gap"}, 16'hBC50, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        string s;
        logic [15:0] mc;
        int n, sofs, bad;

        // Reset state
        step();
        step();
        chk("rst_word", {13'b0, tx_kflag, tx_sof, tx_eof, tx_data}, {13'b0, 3'b100, 16'hBC50});
        chk("rst_err", {29'b0, err_underrun, err_sync, err_len}, 32'd0);
        chk("rst_frm_rdreq", {15'b0, rdreq, frm_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("rdreq_after_rst", 32'(rdreq), 32'd1);

        // CRC model against the CRC-16/CCITT-FALSE check value
        s = "123456789";
        mc = 16'hFFFF;
        for (int i = 0; i < s.len(); i++) mc = crc_byte(mc, s[i]);
        chk("crc_model", 32'(mc), 32'h29B1);

        // 3-word frame
        payload = '{16'h0001, 16'h0002, 16'h0003};
        push_frame();
        check_frame("f3", 1'b0);

        // Back-to-back frames: second sync right after the gap
        payload = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        push_frame();
        payload = '{16'hA5A5, 16'h5A5A, 16'hFFFF};
        push_frame();
        payload = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        check_frame("b2b_a", 1'b0);
        payload = '{16'hA5A5, 16'h5A5A, 16'hFFFF};
        check_frame("b2b_b", 1'b1);
        chk("occ_max", 32'(occ_max <= BUF_DEPTH), 32'd1);

        // Non-SOP word while idle is dropped with one err_sync pulse
        src.push_back({2'b00, 16'h7777});
        n = 0;
        sofs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (err_sync) n++;
            if (tx_sof) sofs++;
        end
        chk("idle_drop_err_sync", 32'(n), 32'd1);
        chk("idle_drop_no_sof", 32'(sofs), 32'd0);

        // SOP inside a frame aborts it, then that SOP starts a new frame
        src.push_back({2'b10, 16'h0A01});
        src.push_back({2'b00, 16'h0A02});
        payload = '{16'h0B01, 16'h0B02, 16'h0B03};
        push_frame();
        wait_sof("sop_mid");
        step();
        chk_word("sop_mid_w1", 16'h0A01, 1'b0, 1'b0, 1'b0);
        step();
        chk_word("sop_mid_w2", 16'h0A02, 1'b0, 1'b0, 1'b0);
        step();
        chk_word("sop_mid_abort", 16'hFE00, 1'b1, 1'b0, 1'b1);
        chk("sop_mid_err_sync", 32'(err_sync), 32'd1);
        for (int g = 0; g < GAP_WORDS; g++) begin
            step();
            chk_word("sop_mid_gap", 16'hBC50, 1'b1, 1'b0, 1'b0);
        end
        check_frame("resync", 1'b1);

        // Upstream stall mid-frame
        src.push_back({2'b10, 16'h0C01});
        src.push_back({2'b00, 16'h0C02});
        wait_sof("stall");
        step();
        chk_word("stall_w1", 16'h0C01, 1'b0, 1'b0, 1'b0);
        step();
        chk_word("stall_w2", 16'h0C02, 1'b0, 1'b0, 1'b0);
        step();
        chk_word("stall_abort", 16'hFE00, 1'b1, 1'b0, 1'b1);
        chk("stall_err_underrun", 32'(err_underrun), 32'd1);
        src.push_back({2'b00, 16'h0C03});
        src.push_back({2'b00, 16'h0C04});
        src.push_back({2'b01, 16'h0C05});
        for (int g = 0; g < GAP_WORDS; g++) begin
            step();
            chk_word("stall_gap", 16'hBC50, 1'b1, 1'b0, 1'b0);
        end
        sofs = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx_sof || !tx_kflag) sofs++;
        end
        chk("stall_late_dropped", 32'(sofs), 32'd0);
        chk("stall_frm_cnt", 32'(frm_cnt), 32'(exp_frm));

        // Overlong frame: 1025 words without EOP
        payload.delete();
        for (int i = 0; i < 1025; i++) payload.push_back(16'(i) ^ 16'h3C00);
        for (int i = 0; i < 1025; i++) src.push_back({(i == 0), 1'b0, payload[i]});
        wait_sof("len");
        bad = 0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            step();
            if ({tx_kflag, tx_eof, tx_data} !== {2'b00, payload[i]}) bad++;
            if (err_len || err_underrun || err_sync) bad++;
        end
        chk("len_payload_words", 32'(bad), 32'd0);
        step();
        chk_word("len_abort", 16'hFE00, 1'b1, 1'b0, 1'b1);
        chk("len_err_len", 32'(err_len), 32'd1);
        for (int g = 0; g < GAP_WORDS; g++) begin
            step();
            chk_word("len_gap", 16'hBC50, 1'b1, 1'b0, 1'b0);
        end
        chk("len_frm_cnt", 32'(frm_cnt), 32'(exp_frm));

        // Reset mid-body
        payload = '{16'h0D01, 16'h0D02, 16'h0D03, 16'h0D04, 16'h0D05, 16'h0D06};
        push_frame();
        wait_sof("rst_mid");
        step();
        chk_word("rst_mid_w1", 16'h0D01, 1'b0, 1'b0, 1'b0);
        step();
        chk_word("rst_mid_w2", 16'h0D02, 1'b0, 1'b0, 1'b0);
        #10;
        rst = 1'b1;
        src.delete();
        #5;
        chk_word("rst_mid_async", 16'hBC50, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk_word("rst_mid_first", 16'hBC50, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_frm_cnt", 32'(frm_cnt), 32'd0);
        exp_frm = 0;
        payload = '{16'h0E01, 16'h0E02};
        push_frame();
        check_frame("post_rst", 1'b0);

        // Link disable stops new requests
        tx_en = 1'b0;
        step();
        step();
        chk("tx_en_off_rdreq", 32'(rdreq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slink_tx_framer.md
SLINK_TX_FRAMER -- requirements
Module: slink_tx_framer

Interface
REQ-001 Parameter BUF_DEPTH, 4, entries in the internal receive buffer (power of 2, minimum 4).
REQ-002 Parameter MAX_LEN, 1024, maximum payload words per frame.
REQ-003 Parameter GAP_WORDS, 2, idle words emitted after each CRC word.
REQ-004 Port clk_12_5m  in  1  sole clock.
REQ-005 Port rst_12_5m  in  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 Port tx_en  in  1  link enable from the slink control.
REQ-007 Port mmtx_slink_dval  in  1  upstream word valid, exactly 1 cycle after slink_mmtx_rdreq.
REQ-008 Port mmtx_slink_data  in  18  upstream word: [17]=SOP, [16]=EOP, [15:0]=payload.
REQ-009 Port slink_mmtx_rdreq  out  1  upstream read request, one word per asserted cycle.
REQ-010 Port tx_data  out  16  line word, valid every cycle.
REQ-011 Port tx_kflag  out  1  marks tx_data as a control word (idle, sync or abort).
REQ-012 Port tx_sof  out  1  high with the sync word.
REQ-013 Port tx_eof  out  1  high with the CRC word or the abort word.
REQ-014 Port err_underrun / err_sync / err_len  out  1 each  single-cycle error pulses.
REQ-015 Port frm_cnt  out  16  count of good frames sent, wraps 0xFFFF->0.

Function
REQ-016 Receive buffer: FIFO of BUF_DEPTH 18-bit entries; every cycle with dval high writes one entry.
REQ-017 rdreq = tx_en AND (occupancy + outstanding requests < BUF_DEPTH); this guarantees no overflow, and words read past an EOP stay buffered for the next frame.
REQ-018 FSM states: IDLE, SYNC, BODY, CRC, GAP, ABORT.
REQ-019 IDLE: emit 16'hBC50 with kflag=1; a head entry without SOP is popped and discarded with an err_sync pulse; a head entry with SOP moves to SYNC.
REQ-020 SYNC: emit 16'hEB90 with kflag=1 and sof=1, no pop, initialise CRC to 16'hFFFF and length to 0, then go to BODY.
REQ-021 BODY: pop the head each cycle; emit payload with kflag=0; update CRC-16/CCITT (poly 0x1021, MSB first, high byte then low byte); increment length.
REQ-022 BODY with an EOP word: after emitting that word, go to CRC; an SOP+EOP word is a valid 1-word frame.
REQ-023 CRC: emit the final CRC register value (no inversion) with kflag=0 and eof=1; increment frm_cnt; go to GAP.
REQ-024 GAP: emit GAP_WORDS idle words, then return to IDLE.
REQ-025 BODY with an empty buffer: pulse err_underrun and go to ABORT.
REQ-026 BODY with an SOP head and no EOP: do not pop; pulse err_sync and go to ABORT; the head is kept for the next frame.
REQ-027 BODY when length reaches MAX_LEN without EOP: pulse err_len and go to ABORT.
REQ-028 ABORT: emit 16'hFE00 with kflag=1 and eof=1 for one cycle; go to GAP; pop and discard non-SOP entries until an SOP or an empty buffer; frm_cnt is not incremented.
REQ-029 All outputs are registered; the sync word appears 1 cycle after an SOP head is seen in IDLE.
REQ-030 tx_en deassertion blocks new requests only; the frame in progress completes normally.

Reset
REQ-031 Reset state: IDLE, buffer empty, outstanding=0, rdreq=0, tx_data=16'hBC50, kflag=1, sof=eof=0, all err=0, frm_cnt=0.
REQ-032 Reset asserted mid-frame discards the frame with no CRC or abort word emitted; the first output after release is an idle word.

Structure
REQ-033 Idle/sync/abort codes, the CRC polynomial/init values and the state encoding live in the shared DEFINES package.
REQ-034 The receive buffer is one sub-module, slink_rxbuf (synchronous FIFO with occupancy output); FSM and CRC stay in the top level.

Verification
REQ-035 3-word frame 0x0001,0x0002,0x0003 (SOP on first, EOP on last) -> EB90 (sof), 0001, 0002, 0003, CRC equal to the model (model self-checked: ASCII "123456789" -> 0x29B1), then 2x BC50; frm_cnt=1.
REQ-036 Two back-to-back frames with continuous dval -> second sync word exactly GAP_WORDS+1 cycles after the first CRC word; rdreq never drives occupancy above 4.
REQ-037 Upstream stalls mid-frame (dval low for 3 cycles) -> err_underrun pulse, FE00 with eof=1, 2 idles; the late words up to EOP are discarded; frm_cnt unchanged.
REQ-038 1025 words with no EOP -> err_len after 1024 payload words, then FE00.
REQ-039 Non-SOP word in IDLE -> err_sync pulse and the word is dropped; SOP during BODY -> FE00, then a new frame starts with that SOP.
REQ-040 Reset pulse mid-BODY -> BC50 on the next cycle, counters 0; the next frame is sent intact.
